// File: rtl/obstacle_pkg.sv
// ============================================================================
// Module  : obstacle_pkg
// Brief   : Shared types, widths and LFSR helper for the obstacle scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package obstacle_pkg;

  localparam int CNT_W  = 9;
  localparam int LFSR_W = 9;

  // x^9 + x^5 + 1 expressed as shift-register tap positions
  localparam int LFSR_TAP_A = 8;
  localparam int LFSR_TAP_B = 4;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 9'h1A5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_SPAWN = 3'd3,
    ST_HALT  = 3'd4
  } sched_state_t;

  localparam logic [1:0] TYPE_SMALL = 2'd0;
  localparam logic [1:0] TYPE_LARGE = 2'd1;
  localparam logic [1:0] TYPE_BIRD  = 2'd2;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spawn_timer.sv
// ============================================================================
// Module  : spawn_timer
// Brief   : Loadable down counter with enable and zero flag; saturates at 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spawn_timer
  import obstacle_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/obstacle_scheduler.sv
// ============================================================================
// Module  : obstacle_scheduler
// Brief   : Randomised obstacle spawn scheduler with ready/valid handshake.
//           Define OBSTACLE_BIRD_EN to allow bird obstacles (type 2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int               MIN_GAP   = 40,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             game_start,
  input  logic             game_over,
  input  logic [1:0]       speed_lvl,
  input  logic             spawn_ready,
  output logic             spawn_valid,
  output logic [1:0]       spawn_type,
  output logic [CNT_W-1:0] gap_count,
  output logic             active,
  output logic [7:0]       spawn_total
);

  localparam logic [CNT_W-1:0] C_MIN_GAP = CNT_W'(MIN_GAP);

  if ((MIN_GAP < 1) || (MIN_GAP > 383)) begin : g_bad_min_gap
    $error("obstacle_scheduler: MIN_GAP out of range 1..383");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("obstacle_scheduler: LFSR_SEED must be nonzero");
  end

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [1:0]        r_type;
  logic [7:0]        r_total;

  logic              w_load;
  logic              w_cnt_en;
  logic              w_latch_type;
  logic              w_accept;
  logic              w_zero;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_reload;
  logic [1:0]        w_type_map;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // game_over pre-empts every state and suppresses all datapath side effects
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_cnt_en     = 1'b0;
    w_latch_type = 1'b0;
    w_accept     = 1'b0;
    if (game_over) begin
      w_next_state = ST_HALT;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (game_start) begin
            w_next_state = ST_ARM;
          end
        end
        ST_ARM: begin
          w_load       = 1'b1;
          w_next_state = ST_COUNT;
        end
        ST_COUNT: begin
          if (tick) begin
            if (w_zero) begin
              w_latch_type = 1'b1;
              w_next_state = ST_SPAWN;
            end else begin
              w_cnt_en = 1'b1;
            end
          end
        end
        ST_SPAWN: begin
          if (spawn_ready) begin
            w_accept     = 1'b1;
            w_next_state = ST_ARM;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Max sum 383 + 127 = 510 stays inside 9 bits
  assign w_reload = C_MIN_GAP + ({2'b00, r_lfsr[6:0]} >> speed_lvl);

  spawn_timer #(
    .W (CNT_W)
  ) u_spawn_timer (
    .clk        (clock),
    .rst        (reset),
    .i_load     (w_load),
    .i_load_val (w_reload),
    .i_en       (w_cnt_en),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_load) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  always_comb begin
    w_type_map = TYPE_SMALL;
    case (r_lfsr[8:7])
      2'b10:   w_type_map = TYPE_LARGE;
`ifdef OBSTACLE_BIRD_EN
      2'b11:   w_type_map = TYPE_BIRD;
`else
      2'b11:   w_type_map = TYPE_LARGE;
`endif
      default: w_type_map = TYPE_SMALL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_type  <= TYPE_SMALL;
      r_total <= 8'd0;
    end else begin
      if (w_latch_type) begin
        r_type <= w_type_map;
      end
      if (w_accept) begin
        r_total <= r_total + 8'd1;
      end
    end
  end

  assign spawn_valid = (r_state == ST_SPAWN);
  assign active      = (r_state == ST_COUNT) || (r_state == ST_SPAWN);
  assign spawn_type  = r_type;
  assign gap_count   = w_count;
  assign spawn_total = r_total;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
// ============================================================================
// Module  : tb_obstacle_scheduler
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized stimulus against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obstacle_scheduler;
  import obstacle_pkg::*;

  localparam int MIN_GAP = 40;
  localparam int SEED    = 'h1A5;
`ifdef OBSTACLE_BIRD_EN
  localparam int BIRD = 2;
`else
  localparam int BIRD = 1;
`endif

  logic       clock = 1'b0;
  logic       reset, tick, game_start, game_over, spawn_ready;
  logic [1:0] speed_lvl;
  logic       spawn_valid, active;
  logic [1:0] spawn_type;
  logic [8:0] gap_count;
  logic [7:0] spawn_total;

  obstacle_scheduler #(.MIN_GAP(MIN_GAP), .LFSR_SEED(9'h1A5)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .game_start  (game_start),
    .game_over   (game_over),
    .speed_lvl   (speed_lvl),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .gap_count   (gap_count),
    .active      (active),
    .spawn_total (spawn_total)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 10, P_LOAD = 11, P_WAIT = 12, P_OFFER = 13, P_STOP = 14;
  int m_phase, m_gap, m_lfsr, m_type, m_total;
  int tmap [4] = '{0, 0, 1, BIRD};

  task automatic model_step();
    if (reset) begin
      m_phase = P_IDLE; m_lfsr = SEED; m_gap = 0; m_type = 0; m_total = 0;
    end else if (game_over) begin
      m_phase = P_STOP;
    end else begin
      case (m_phase)
        P_IDLE, P_STOP: if (game_start) m_phase = P_LOAD;
        P_LOAD: begin
          m_gap   = MIN_GAP + ((m_lfsr % 128) / (1 << speed_lvl));
          m_lfsr  = ((m_lfsr * 2) % 512) + (((m_lfsr / 256) + (m_lfsr / 16)) % 2);
          m_phase = P_WAIT;
        end
        P_WAIT: if (tick) begin
          if (m_gap == 0) begin
            m_type  = tmap[m_lfsr / 128];
            m_phase = P_OFFER;
          end else begin
            m_gap = m_gap - 1;
          end
        end
        P_OFFER: if (spawn_ready) begin
          m_total = (m_total + 1) % 256;
          m_phase = P_LOAD;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [31:0] pk(int v, int t, int g, int a, int tot);
    return {11'd0, 1'(v), 2'(t), 9'(g), 1'(a), 8'(tot)};
  endfunction

  function automatic logic [31:0] model_out();
    return pk(m_phase == P_OFFER, m_type, m_gap,
              (m_phase == P_WAIT) || (m_phase == P_OFFER), m_total);
  endfunction

  function automatic logic [31:0] dut_out();
    return {11'd0, spawn_valid, spawn_type, gap_count, active, spawn_total};
  endfunction

  task automatic drive(input logic r, t, s, o, input logic [1:0] sp, input logic rd);
    reset = r; tick = t; game_start = s; game_over = o; speed_lvl = sp; spawn_ready = rd;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    chk("outputs{valid,type,gap,active,total}", dut_out(), model_out());
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        r, t, s, o;
    logic [1:0]  sp;
    logic        rd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [14];

  task automatic run_ticks_until_valid(output int n);
    n = 0;
    for (int k = 0; k < 600; k++) begin
      if (spawn_valid) break;
      drive(0, 1, 0, 0, speed_lvl, 0);
      cyc();
      n++;
    end
  endtask

  int n_ticks, accepted, cycles, lfsr_zero, bird_seen;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    tbl[0]  = '{1, 0, 0, 0, 2'd0, 0, pk(0, 0, 0,  0, 0)};
    tbl[1]  = '{0, 0, 1, 0, 2'd0, 0, pk(0, 0, 0,  0, 0)};
    tbl[2]  = '{0, 0, 0, 0, 2'd0, 0, pk(0, 0, 77, 1, 0)};
    tbl[3]  = '{0, 1, 0, 0, 2'd0, 0, pk(0, 0, 76, 1, 0)};
    tbl[4]  = '{0, 0, 0, 0, 2'd0, 1, pk(0, 0, 76, 1, 0)};
    tbl[5]  = '{0, 1, 1, 0, 2'd0, 0, pk(0, 0, 75, 1, 0)};
    tbl[6]  = '{0, 0, 1, 1, 2'd0, 0, pk(0, 0, 75, 0, 0)};
    tbl[7]  = '{0, 0, 1, 0, 2'd0, 0, pk(0, 0, 75, 0, 0)};
    tbl[8]  = '{0, 0, 0, 0, 2'd1, 0, pk(0, 0, 77, 1, 0)};
    tbl[9]  = '{1, 1, 1, 0, 2'd0, 1, pk(0, 0, 0,  0, 0)};
    tbl[10] = '{0, 0, 1, 1, 2'd0, 0, pk(0, 0, 0,  0, 0)};
    tbl[11] = '{0, 0, 0, 0, 2'd0, 1, pk(0, 0, 0,  0, 0)};
    tbl[12] = '{0, 0, 1, 0, 2'd0, 0, pk(0, 0, 0,  0, 0)};
    tbl[13] = '{0, 0, 0, 0, 2'd3, 0, pk(0, 0, 44, 1, 0)};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].o, tbl[i].sp, tbl[i].rd);
      model_step();
      @(posedge clock);
      #1;
      chk($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
    end

    // first spawn from seed: reload 77, 78 ticks, large cactus
    drive(1, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("reload speed0", 32'(gap_count), 77);
    chk("lfsr after arm", 32'(dut.r_lfsr), 'h14B);
    run_ticks_until_valid(n_ticks);
    chk("ticks to spawn", n_ticks, 78);
    chk("spawn_type first", 32'(spawn_type), 1);

    // stalled handshake: outputs frozen while ticks run
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 0, 0, 0); cyc();
      chk("stall valid/type/gap", {spawn_valid, spawn_type, gap_count}, {1'b1, 2'd1, 9'd0});
    end
    drive(0, 0, 0, 0, 0, 1); cyc();
    chk("total after accept", 32'(spawn_total), 1);
    chk("state after accept", 32'(dut.r_state), 32'(ST_ARM));

    // speed 2 reload, then game_over mid-count and mid-spawn
    drive(1, 0, 0, 0, 2, 0); cyc();
    drive(0, 0, 1, 0, 2, 0); cyc();
    drive(0, 0, 0, 0, 2, 0); cyc();
    chk("reload speed2", 32'(gap_count), 49);
    for (int k = 0; k < 5; k++) begin drive(0, 1, 0, 0, 2, 0); cyc(); end
    drive(0, 1, 0, 1, 2, 0); cyc();
    chk("halt mid-count", 32'(dut.r_state), 32'(ST_HALT));
    chk("halt mid-count valid/total", {spawn_valid, spawn_total}, 0);
    drive(0, 0, 1, 1, 2, 0); cyc();
    chk("start+over stays halt", 32'(dut.r_state), 32'(ST_HALT));
    drive(0, 0, 1, 0, 2, 0); cyc();
    drive(0, 0, 0, 0, 2, 0); cyc();
    run_ticks_until_valid(n_ticks);
    chk("valid before over", 32'(spawn_valid), 1);
    drive(0, 0, 0, 1, 2, 0); cyc();
    chk("halt mid-spawn", 32'(dut.r_state), 32'(ST_HALT));
    chk("halt mid-spawn valid/total", {spawn_valid, spawn_total}, 0);

    // reset while counting at gap 30
    drive(1, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc();
    for (int k = 0; k < 600; k++) begin
      if (gap_count == 9'd30) break;
      drive(0, 1, 0, 0, 0, 0); cyc();
    end
    chk("reached gap 30", 32'(gap_count), 30);
    drive(1, 1, 1, 0, 3, 1); cyc();
    chk("reset outputs", dut_out(), pk(0, 0, 0, 0, 0));
    chk("reset lfsr", 32'(dut.r_lfsr), 'h1A5);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(199) == 0, $urandom_range(1), $urandom_range(7) == 0,
            $urandom_range(59) == 0, 2'($urandom_range(3)), $urandom_range(2) == 0);
      cyc();
    end

    // long run of 600 spawns with immediate acceptance
    drive(1, 0, 0, 0, 3, 1); cyc();
    drive(0, 0, 1, 0, 3, 1); cyc();
    accepted = 0; cycles = 0; lfsr_zero = 0; bird_seen = 0;
    while ((accepted < 600) && (cycles < 80000)) begin
      if (spawn_valid && spawn_ready) accepted++;
      drive(0, 1, 0, 0, 2'($urandom_range(3, 2)), 1);
      cyc();
      cycles++;
      if (dut.r_lfsr == 9'd0) lfsr_zero++;
      if (spawn_valid && (spawn_type == 2'd2)) bird_seen++;
    end
    chk("600 spawns within budget", accepted, 600);
    chk("total wraps to 600 mod 256", 32'(spawn_total), 88);
    chk("lfsr zero cycles", lfsr_zero, 0);
`ifndef OBSTACLE_BIRD_EN
    chk("bird spawns without bird enable", bird_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter MIN_GAP, default 40: minimum spawn gap in ticks; legal range 1..383.
REQ-002 Parameter LFSR_SEED, default 9'h1A5: LFSR reset value; SHALL be nonzero.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  frame-rate enable; one pulse advances the gap counter by one.
REQ-006 game_start  input  1  level pulse; starts or restarts spawning.
REQ-007 game_over  input  1  level; stops spawning.
REQ-008 speed_lvl  input  2  gap shrink factor 0..3.
REQ-009 spawn_ready  input  1  obstacle renderer accepts the spawn.
REQ-010 spawn_valid  output  1  spawn request pending.
REQ-011 spawn_type  output  2  0 small cactus, 1 large cactus, 2 bird, 3 unused.
REQ-012 gap_count  output  9  current countdown value.
REQ-013 active  output  1  high in COUNT or SPAWN.
REQ-014 spawn_total  output  8  accepted spawns, wraps 255->0.

Function
REQ-015 FSM states: IDLE, ARM, COUNT, SPAWN, HALT.
REQ-016 IDLE/HALT + game_start=1, game_over=0 -> ARM; otherwise hold.
REQ-017 ARM lasts exactly one cycle: load gap_count = MIN_GAP + (lfsr[6:0] >> speed_lvl); advance LFSR once; -> COUNT.
REQ-018 Reload sum SHALL be 9-bit unsigned with no overflow (max 383+127 = 510).
REQ-019 COUNT, tick=1, gap_count!=0: decrement by 1. tick=0: hold.
REQ-020 COUNT, tick=1, gap_count==0: -> SPAWN; latch spawn_type from the current LFSR value; spawn_valid=1 from the next cycle.
REQ-021 spawn_type mapping: lfsr[8:7] = 00/01 -> 0; 10 -> 1; 11 -> 2 (see REQ-033).
REQ-022 SPAWN: spawn_valid and spawn_type stay stable until spawn_ready=1; ticks are ignored and gap_count holds 0.
REQ-023 SPAWN and spawn_ready=1: spawn_valid=0 next cycle; spawn_total += 1; -> ARM.
REQ-024 spawn_ready while not in SPAWN SHALL be ignored.
REQ-025 LFSR: 9-bit Fibonacci x^9+x^5+1; next = {lfsr[7:0], lfsr[8]^lfsr[4]}; advances only in ARM; never reaches zero.
REQ-026 game_over=1 in any state -> HALT next cycle; spawn_valid=0 next cycle with no handshake; spawn_total is not incremented.
REQ-027 game_over and game_start both high: game_over wins.
REQ-028 game_start while in ARM, COUNT or SPAWN SHALL be ignored.
REQ-029 speed_lvl is sampled only in ARM; changes mid-count take effect at the next reload.

Reset
REQ-030 reset=1: state=IDLE, lfsr=LFSR_SEED, gap_count=0, spawn_valid=0, spawn_type=0, active=0, spawn_total=0.
REQ-031 reset overrides all other inputs, including mid-COUNT and mid-SPAWN; any pending spawn is dropped.

Configuration
REQ-032 Macro OBSTACLE_BIRD_EN gates bird generation.
REQ-033 Macro defined: lfsr[8:7]=11 -> type 2. Macro undefined: lfsr[8:7]=11 -> type 1; type 2 is never produced.

Structure
REQ-034 Package obstacle_pkg: FSM state enum, spawn_type codes, CNT_W=9, LFSR polynomial taps, default seed.
REQ-035 Sub-module spawn_timer: 9-bit loadable down counter with load, enable and zero flag; it SHALL implement gap_count.

Verification
REQ-036 Default parameters, speed_lvl=0, pulse game_start -> ARM loads 77 (40+37); spawn_valid rises one cycle after the 78th tick; spawn_type=1; LFSR=9'h14B.
REQ-037 Same as REQ-036 but speed_lvl=2 -> reload is 49 (40+9).
REQ-038 Hold spawn_ready=0 for 20 cycles with ticks running -> spawn_valid and spawn_type stable, gap_count=0; then spawn_ready=1 for one cycle -> spawn_total=1, state ARM next cycle.
REQ-039 Assert game_over mid-COUNT and, in a second run, mid-SPAWN -> HALT next cycle, spawn_valid=0, spawn_total unchanged; assert game_over and game_start together -> remains HALT.
REQ-040 Assert reset while gap_count=30 -> all outputs at their REQ-030 values on the next cycle, lfsr=9'h1A5.
REQ-041 Run 600 spawns with immediate ready -> lfsr never 0, spawn_total wraps correctly; with OBSTACLE_BIRD_EN undefined, no type 2 is ever produced.
